// File: rtl/alu_pipe_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add MUL,
// result presented under a valid/ready handshake with a one-deep output register.
module alu_pipe_mc #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             OVERFLOW,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_FWD = 3'b000, OP_ADD = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
                         OP_SUB = 3'b100, OP_MUL = 3'b101, OP_SLL = 3'b110, OP_SRA = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  state_t state, state_nxt;

  logic               accept, is_mul, mul_done;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [WIDTH:0]     sum, diff;
  logic [SW-1:0]      sh;
  logic [2*WIDTH-1:0] mcand, acc, prod;
  logic [WIDTH-1:0]   mplier;
  logic [SW-1:0]      cnt;

  assign accept   = IN_VALID & IN_READY;
  assign is_mul   = (SELECT == OP_MUL);
  assign mul_done = (state == BUSY) && (cnt == SW'(WIDTH - 1));
  assign prod     = acc + (mplier[0] ? mcand : '0);

  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_mul ? BUSY : HOLD;
      BUSY: if (mul_done) state_nxt = HOLD;
      HOLD: if (OUT_READY) state_nxt = accept ? (is_mul ? BUSY : HOLD) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs
  always_comb begin
    IN_READY  = !RESET && ((state == IDLE) || ((state == HOLD) && OUT_READY));
    OUT_VALID = (state == HOLD);
  end

  // single-cycle ops, evaluated on the live operands at the accept edge
  always_comb begin
    sh      = DATA2[SW-1:0];
    sum     = {1'b0, DATA1} + {1'b0, DATA2};
    diff    = {1'b0, DATA1} - {1'b0, DATA2};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (SELECT)
      OP_FWD: alu_res = DATA2;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) && (sum[WIDTH-1] != DATA1[WIDTH-1]);
      end
      OP_AND: alu_res = DATA1 & DATA2;
      OP_OR:  alu_res = DATA1 | DATA2;
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (DATA1[WIDTH-1] != DATA2[WIDTH-1]) && (diff[WIDTH-1] != DATA1[WIDTH-1]);
      end
      OP_SLL: alu_res = DATA1 << sh;
      OP_SRA: alu_res = $signed(DATA1) >>> sh;
      default: alu_res = '0;
    endcase
  end

  // multiplier iteration and result register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      RESULT   <= '0;
      ZERO     <= 1'b0;
      CARRY    <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      if (accept && is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, DATA1};
        mplier <= DATA2;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == BUSY) begin
        acc    <= prod;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
      // last multiplier bit folds straight into the result so HOLD lands WIDTH edges after accept
      if (accept && !is_mul) begin
        RESULT   <= alu_res;
        ZERO     <= (alu_res == '0);
        CARRY    <= alu_c;
        OVERFLOW <= alu_v;
      end else if (mul_done) begin
        RESULT   <= prod[WIDTH-1:0];
        ZERO     <= (prod[WIDTH-1:0] == '0);
        CARRY    <= |prod[2*WIDTH-1:WIDTH];
        OVERFLOW <= 1'b0;
      end
    end
  end
endmodule
